// File: rtl/mux2_pkg.sv
// Shared definitions for the mux2 output deserializer slice.
//   buf_state_t : states of the one-entry output buffer
//   DEF_WIDTH   : default number of samples per word
//   cnt_w()     : width of a counter that must hold 0..width
package mux2_pkg;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mux2_bit_collector.sv
// Serial-to-parallel collector for the mux output bit.
//   clk, rst   : clock, synchronous active-high reset
//   y_in       : serial sample
//   bit_valid  : take y_in this cycle
//   clear      : drop partial word (wins over bit_valid)
//   bit_count  : samples collected toward the current word
//   done       : this cycle's sample completes a word
//   word_next  : the completed word, including the current y_in
module mux2_bit_collector
  import mux2_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic [CW-1:0]    bit_count,
  output logic             done,
  output logic [WIDTH-1:0] word_next
);

  logic [WIDTH-1:0] shift_q;
  logic             take;

  assign take = bit_valid && !clear;

  // First sample must end in bit 0 for LSB-first, so new bits enter at the
  // MSB and migrate down; MSB-first is the mirror image.
  always_comb begin
    word_next = LSB_FIRST ? {y_in, shift_q[WIDTH-1:1]}
                          : {shift_q[WIDTH-2:0], y_in};
  end

  assign done = take && (bit_count == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_q   <= '0;
      bit_count <= '0;
    end else if (take) begin
      shift_q   <= word_next;
      bit_count <= done ? '0 : bit_count + CW'(1);
    end
  end

endmodule

// File: rtl/mux2_out_deserializer.sv
// Deserializer behind the 2:1 mux: gathers WIDTH samples of y into a word
// and holds it in a one-entry valid/ready buffer with sticky overflow.
//   clk, rst    : clock, synchronous active-high reset
//   y_in        : mux output bit
//   bit_valid   : sample y_in this cycle
//   clear       : reset collector and overflow; held word kept
//   word_data   : held word
//   word_valid  : word_data is unaccepted
//   word_ready  : consumer accepts when word_valid && word_ready
//   bit_count   : samples collected toward the current word
//   overflow    : sticky, a completed word was dropped
module mux2_out_deserializer
  import mux2_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CW-1:0]    bit_count,
  output logic             overflow
);

  buf_state_t       state;
  logic             done;
  logic [WIDTH-1:0] word_next;
  logic             accept;

  mux2_bit_collector #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST)
  ) u_collector (
    .clk      (clk),
    .rst      (rst),
    .y_in     (y_in),
    .bit_valid(bit_valid),
    .clear    (clear),
    .bit_count(bit_count),
    .done     (done),
    .word_next(word_next)
  );

  assign word_valid = (state == BUF_FULL);
  assign accept     = word_valid && word_ready;

  // NOTE: only control and data registers are reset here; there is no
  // memory array, so every flop gets a defined reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BUF_EMPTY;
      word_data <= '0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        BUF_EMPTY: begin
          if (done) begin
            word_data <= word_next;
            state     <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (done && accept) begin
            word_data <= word_next;     // slot frees and refills on one edge
          end else if (done) begin
            overflow  <= 1'b1;          // new word dropped, old one kept
          end else if (accept) begin
            state     <= BUF_EMPTY;     // word_data intentionally left as is
          end
        end
        default: state <= BUF_EMPTY;
      endcase
      // done is already masked by clear, so this never races a new overflow.
      if (clear) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_out_deserializer.sv
// Directed bench: two instances (LSB-first and MSB-first) share stimulus.
module tb_mux2_out_deserializer;

  logic       clk = 1'b0;
  logic       rst, y_in, bit_valid, clear, word_ready;
  logic [7:0] data_l, data_m;
  logic       valid_l, valid_m, ovf_l, ovf_m;
  logic [3:0] cnt_l, cnt_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux2_out_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .y_in(y_in), .bit_valid(bit_valid), .clear(clear),
    .word_data(data_l), .word_valid(valid_l), .word_ready(word_ready),
    .bit_count(cnt_l), .overflow(ovf_l)
  );

  mux2_out_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .y_in(y_in), .bit_valid(bit_valid), .clear(clear),
    .word_data(data_m), .word_valid(valid_m), .word_ready(word_ready),
    .bit_count(cnt_m), .overflow(ovf_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    y_in = b; bit_valid = 1'b1; word_ready = rdy;
    tick();
    bit_valid = 1'b0; word_ready = 1'b0;
  endtask

  // seq[7] is the first sample sent; gap idle cycles follow each sample;
  // word_ready is raised only on the final sample when last_rdy is set.
  task automatic send_word(input logic [7:0] seq, input int gap, input logic last_rdy);
    for (int i = 7; i >= 0; i--) begin
      send_bit(seq[i], (i == 0) ? last_rdy : 1'b0);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic pulse_ready();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; y_in = 1'b0; bit_valid = 1'b0; clear = 1'b0; word_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_data", data_l, 8'h00);
    chk("rst_valid", valid_l, 1'b0);
    chk("rst_count", cnt_l, 4'd0);
    chk("rst_ovf", ovf_l, 1'b0);

    // Sequence 1,0,1,1,0,0,1,0: LSB-first 0x4D, MSB-first 0xB2.
    for (int i = 7; i >= 1; i--) send_bit(logic'((8'b10110010 >> i) & 8'h01), 1'b0);
    chk("t1_count7", cnt_l, 4'd7);
    chk("t1_valid_early", valid_l, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("t1_valid", valid_l, 1'b1);
    chk("t1_data_lsb", data_l, 8'h4D);
    chk("t2_data_msb", data_m, 8'hB2);
    chk("t1_count0", cnt_l, 4'd0);
    chk("t1_ovf", ovf_l, 1'b0);
    pulse_ready();
    chk("t2_valid_after_accept", valid_m, 1'b0);
    chk("t2_data_held", data_m, 8'hB2);

    // Overflow: 0x4D accepted into buffer, 0xFF dropped.
    send_word(8'b10110010, 0, 1'b0);
    send_word(8'b11111111, 0, 1'b0);
    chk("t3_ovf", ovf_l, 1'b1);
    chk("t3_data_kept", data_l, 8'h4D);
    chk("t3_data_kept_msb", data_m, 8'hB2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_ovf_cleared", ovf_l, 1'b0);
    chk("t3_valid_kept", valid_l, 1'b1);
    chk("t3_data_after_clear", data_l, 8'h4D);

    // Completion and accept on the same edge: refill, no overflow.
    pulse_ready();
    chk("t4_drained", valid_l, 1'b0);
    send_word(8'b11111111, 0, 1'b0);
    chk("t4_first", data_l, 8'hFF);
    send_word(8'b01101001, 0, 1'b1);
    chk("t4_valid", valid_l, 1'b1);
    chk("t4_data_lsb", data_l, 8'h96);
    chk("t4_data_msb", data_m, 8'h69);
    chk("t4_ovf", ovf_l, 1'b0);

    // Reset mid-word.
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    chk("t5_count5", cnt_l, 4'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_data", data_l, 8'h00);
    chk("t5_rst_valid", valid_l, 1'b0);
    chk("t5_rst_count", cnt_l, 4'd0);
    chk("t5_rst_ovf", ovf_l, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
    chk("t5_no_early_word", valid_l, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("t5_valid", valid_l, 1'b1);
    chk("t5_data_lsb", data_l, 8'h80);
    chk("t5_data_msb", data_m, 8'h01);
    pulse_ready();

    // Gapped samples, clear mid-word with a colliding bit_valid.
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1, 1'b0);
      tick(); tick();
    end
    chk("t6_count_hold", cnt_l, 4'd3);
    clear = 1'b1; bit_valid = 1'b1; y_in = 1'b1;
    tick();
    clear = 1'b0; bit_valid = 1'b0;
    chk("t6_clear_count", cnt_l, 4'd0);
    send_word(8'b11001010, 2, 1'b0);
    chk("t6_valid", valid_l, 1'b1);
    chk("t6_data_lsb", data_l, 8'h53);
    chk("t6_data_msb", data_m, 8'hCA);
    chk("t6_count", cnt_m, 4'd0);
    chk("t6_ovf", ovf_m, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux2_out_deserializer.md
Name: mux2_out_deserializer

Overview:
- Downstream stage of the 2:1 logic mux (inputs a/b/c, output y).
- Samples the mux's single-bit output y on qualified cycles and assembles WIDTH consecutive samples into a parallel word.
- Presents each word through a one-entry valid/ready output buffer with sticky overflow detection.
- Turns the mux's combinational bit stream into checkable words for the bench and later stages.

Parameters:
- WIDTH, 8, number of y samples per word (2..32).
- LSB_FIRST, 1, 1: first sample lands in word bit 0; 0: first sample lands in bit WIDTH-1.

Ports:
- clk  input  1  single clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- y_in  input  1  mux output bit y
- bit_valid  input  1  sample y_in this cycle
- clear  input  1  synchronous clear of collector and overflow; held word kept
- word_data  output  WIDTH  assembled word (held buffer)
- word_valid  output  1  word_data holds an unaccepted word
- word_ready  input  1  consumer accepts word when word_valid && word_ready
- bit_count  output  $clog2(WIDTH+1)  samples collected toward the current word
- overflow  output  1  sticky: a completed word was dropped

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset (rst=1 at a clk edge): shift reg=0, bit_count=0, word_data=0, word_valid=0, overflow=0, buffer state=EMPTY. rst has priority over every other input.
- Collector:
  - On bit_valid=1, y_in is shifted in and bit_count increments.
  - LSB_FIRST=1: shift right, insert at MSB, so after WIDTH samples the first sample sits at bit 0.
  - LSB_FIRST=0: shift left, insert at LSB.
  - bit_valid=0: collector holds.
- Word completion:
  - Occurs when bit_valid=1 and bit_count==WIDTH-1.
  - bit_count wraps to 0 on the same edge.
  - The completed word (including the current y_in) is offered to the buffer on that edge.
  - Latency: word_valid rises the cycle after the last sample edge.
- Buffer FSM, 2 states:
  - EMPTY: completion -> load word_data, go FULL.
  - FULL + accept (word_valid && word_ready), no completion -> go EMPTY. word_data holds its last value; it is not cleared.
  - FULL + completion + accept in the same cycle -> load new word, stay FULL (no overflow).
  - FULL + completion without accept -> drop new word, keep old word_data, set overflow, stay FULL.
  - word_valid == (state==FULL).
- overflow: stays 1 until rst or clear.
- clear=1:
  - Sets shift reg=0, bit_count=0, overflow=0.
  - Buffer state and word_data are untouched; an accept in the same cycle is still honoured.
  - A bit_valid in the same cycle is discarded (clear wins over sampling).
- word_ready while EMPTY: ignored.
- rst mid-word discards partial bits and any held word.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package mux2_pkg:
  - typedef buf_state_t {BUF_EMPTY, BUF_FULL}
  - localparam DEF_WIDTH=8
  - function cnt_w(width) returning $clog2(width+1)
- Sub-module mux2_bit_collector: shift register plus bit counter, with a done pulse and parallel word output.
- The top level holds the buffer FSM and overflow logic.

Test Plan:
1. WIDTH=8, LSB_FIRST=1. Feed y_in=1,0,1,1,0,0,1,0 with bit_valid=1 on consecutive cycles, word_ready=0 -> word_valid=1 one cycle after the 8th sample, word_data=0x4D, bit_count=0, overflow=0.
2. Same bit sequence with LSB_FIRST=0 -> word_data=0xB2. Then assert word_ready for one cycle -> word_valid=0 the next cycle.
3. Hold word_ready=0 and send two full words, 0x4D then 0xFF -> after the second word overflow=1 and word_data is still 0x4D. Then pulse clear -> overflow=0, word_valid still 1.
4. Back-to-back words with word_ready=1 during the second word's completion cycle -> word_valid stays 1, word_data=second word, overflow=0.
5. After 5 samples (bit_count=5), assert rst -> all outputs 0 next cycle. Then send 8 fresh samples -> a clean word with no carried-over bits.
6. Interleave bit_valid=0 gaps, e.g. samples every 3rd cycle, plus one clear in the middle of a word -> partial bits discarded, bit_count restarts at 0, and the following 8 valid samples produce the exact expected word.
